// File: rtl/forwarding_scoreboard_if.sv
// Bundle of ID-stage issue/source signals and the forwarding/stall/busy results
// exchanged between the pipeline control (master) and the scoreboard (slave).
interface forwarding_scoreboard_if #(
  parameter int NREG  = 8,
  parameter int DEPTH = 3
);
  localparam int RW = $clog2(NREG);
  localparam int SW = $clog2(DEPTH + 1);

  logic          issue_valid;
  logic          issue_we;
  logic [RW-1:0] issue_rd;
  logic          issue_is_load;
  logic          srcA_use;
  logic          srcB_use;
  logic [RW-1:0] srcA_reg;
  logic [RW-1:0] srcB_reg;
  logic          flush;
  logic [SW-1:0] fwdA_sel;
  logic [SW-1:0] fwdB_sel;
  logic          stall;
  logic [NREG-1:0] busy;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_is_load,
    output srcA_use, srcB_use, srcA_reg, srcB_reg, flush,
    input  fwdA_sel, fwdB_sel, stall, busy
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_is_load,
    input  srcA_use, srcB_use, srcA_reg, srcB_reg, flush,
    output fwdA_sel, fwdB_sel, stall, busy
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Tracks destination registers of instructions in EX..WB, selects the youngest
// forwarding source for each ID operand and raises the load-use stall.
module forwarding_scoreboard #(
  parameter int NREG        = 8,
  parameter int DEPTH       = 3,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  forwarding_scoreboard_if.slave bus
);
  localparam int RW  = $clog2(NREG);
  localparam int SW  = $clog2(DEPTH + 1);
  localparam bit ZEN = (ZERO_REG_EN != 0);

  logic [DEPTH:1]  vld_r;
  logic [DEPTH:1]  ld_r;
  logic [RW-1:0]   rd_r [1:DEPTH];

  logic [SW-1:0]   match_a_s;
  logic [SW-1:0]   match_b_s;
  logic            ld_a_s;
  logic            ld_b_s;
  logic            ok_a_s;
  logic            ok_b_s;
  logic            haz_a_s;
  logic            haz_b_s;
  logic            stall_s;
  logic            issue_s;
  logic [NREG-1:0] busy_s;

  // Scanning oldest to youngest lets the youngest matching stage win.
  function automatic logic [SW:0] youngest(input logic [RW-1:0] src);
    logic [SW:0] res;
    res = {(SW + 1){1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_r[k] && (rd_r[k] == src)) begin
        res = {ld_r[k], SW'(k)};
      end
    end
    return res;
  endfunction

  // Operand lookup, load-use hazard detection and issue qualification.
  always_comb begin
    ok_a_s = bus.srcA_use & ~(ZEN & (bus.srcA_reg == {RW{1'b0}}));
    ok_b_s = bus.srcB_use & ~(ZEN & (bus.srcB_reg == {RW{1'b0}}));
    {ld_a_s, match_a_s} = youngest(bus.srcA_reg);
    {ld_b_s, match_b_s} = youngest(bus.srcB_reg);
    haz_a_s = ok_a_s & (match_a_s != {SW{1'b0}}) & (match_a_s <= SW'(LOAD_LAT)) & ld_a_s;
    haz_b_s = ok_b_s & (match_b_s != {SW{1'b0}}) & (match_b_s <= SW'(LOAD_LAT)) & ld_b_s;
    stall_s = (haz_a_s | haz_b_s) & ~bus.flush;
    issue_s = bus.issue_valid & bus.issue_we & ~stall_s & ~bus.flush
              & ~(ZEN & (bus.issue_rd == {RW{1'b0}}));
  end

  // Per-register pending-write vector.
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int r = 0; r < NREG; r++) begin
      for (int k = 1; k <= DEPTH; k++) begin
        busy_s[r] = busy_s[r] | (vld_r[k] & (rd_r[k] == RW'(r)));
      end
    end
  end

  assign bus.fwdA_sel = (ok_a_s & ~(haz_a_s & ~bus.flush)) ? match_a_s : {SW{1'b0}};
  assign bus.fwdB_sel = (ok_b_s & ~(haz_b_s & ~bus.flush)) ? match_b_s : {SW{1'b0}};
  assign bus.stall    = stall_s;
  assign bus.busy     = busy_s;

  // Pipeline of pending writes; a flush squashes the instructions in ID and EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= {DEPTH{1'b0}};
      ld_r  <= {DEPTH{1'b0}};
      for (int k = 1; k <= DEPTH; k++) begin
        rd_r[k] <= {RW{1'b0}};
      end
    end else begin
      vld_r[1] <= issue_s;
      rd_r[1]  <= bus.issue_rd;
      ld_r[1]  <= bus.issue_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        vld_r[k] <= vld_r[k-1] & ~(bus.flush & (k == 2));
        rd_r[k]  <= rd_r[k-1];
        ld_r[k]  <= ld_r[k-1];
      end
    end
  end
endmodule
